// File: rtl/bank_arbiter.sv
// Round-robin arbiter giving four requesters access to a single registered bank.
// Writes finish in the grant cycle; reads respond two cycles after their grant.
module bank_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic [3:0]  gnt,
  output logic [3:0]  resp_valid,
  output logic [7:0]  resp_data,
  output logic        resp_hit,
  output logic [7:0]  bank_addr,
  output logic [7:0]  bank_data_in,
  output logic        bank_read_enable,
  output logic        bank_write_enable,
  input  logic [7:0]  bank_data_out,
  input  logic        bank_valid_out
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t     state_q;
  logic [1:0] rr_ptr_q;
  logic [1:0] rd_owner_q;
  logic [3:0] resp_valid_q;
  logic [7:0] resp_data_q;
  logic       resp_hit_q;

  logic       win_vld;
  logic [1:0] win_idx;
  logic       grant_ok;
  logic       win_we;

  // Descending scan so the last hit is the first set bit at or above rr_ptr.
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[rr_ptr_q + 2'(k)]) begin
        win_vld = 1'b1;
        win_idx = rr_ptr_q + 2'(k);
      end
    end
  end

  assign grant_ok = win_vld && (state_q == IDLE) && !reset;
  assign win_we   = req_we[win_idx];

  always_comb begin
    gnt               = 4'b0000;
    bank_addr         = 8'h00;
    bank_data_in      = 8'h00;
    bank_read_enable  = 1'b0;
    bank_write_enable = 1'b0;
    if (grant_ok) begin
      gnt               = 4'b0001 << win_idx;
      bank_addr         = req_addr[{win_idx, 3'b000} +: 8];
      bank_data_in      = req_data[{win_idx, 3'b000} +: 8];
      bank_read_enable  = !win_we;
      bank_write_enable = win_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 2'd0;
      rd_owner_q   <= 2'd0;
      resp_valid_q <= 4'b0000;
      resp_data_q  <= 8'h00;
      resp_hit_q   <= 1'b0;
    end else begin
      resp_valid_q <= 4'b0000;
      case (state_q)
        IDLE: begin
          if (grant_ok) begin
            rr_ptr_q <= win_idx + 2'd1;
            if (!win_we) begin
              state_q    <= RD_WAIT;
              rd_owner_q <= win_idx;
            end
          end
        end
        RD_WAIT: begin
          resp_data_q  <= bank_data_out;
          resp_hit_q   <= bank_valid_out;
          resp_valid_q <= 4'b0001 << rd_owner_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_hit   = resp_hit_q;

endmodule

// File: tb/tb_bank_arbiter.sv
// Directed bench for bank_arbiter: a registered bank, a per-cycle reference model
// and literal expectations for the reset, read, write and round-robin scenarios.
module tb_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, req_we;
  logic [31:0] req_addr, req_data;
  logic [3:0]  gnt, resp_valid;
  logic [7:0]  resp_data, bank_addr, bank_data_in, bank_data_out;
  logic        resp_hit, bank_read_enable, bank_write_enable, bank_valid_out;

  always #5 clk = ~clk;

  bank_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data), .gnt(gnt),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
    .bank_addr(bank_addr), .bank_data_in(bank_data_in),
    .bank_read_enable(bank_read_enable), .bank_write_enable(bank_write_enable),
    .bank_data_out(bank_data_out), .bank_valid_out(bank_valid_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Registered bank; contents and valid bits return to a known pattern on reset.
  logic [7:0] bmem [256];
  logic       bvld [256];
  always @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < 256; a++) begin
        bmem[a] <= 8'(a) ^ 8'h3C;
        bvld[a] <= 1'b0;
      end
      bank_data_out  <= 8'h00;
      bank_valid_out <= 1'b0;
    end else begin
      if (bank_write_enable) begin
        bmem[bank_addr] <= bank_data_in;
        bvld[bank_addr] <= 1'b1;
      end
      if (bank_read_enable) begin
        bank_data_out  <= bmem[bank_addr];
        bank_valid_out <= bvld[bank_addr];
      end
    end
  end

  // Reference model: pointer, one pending read, the response it will produce.
  int         m_ptr;
  bit         m_pend;
  int         m_owner;
  logic [7:0] m_paddr;
  int         m_rowner = -1;
  logic [7:0] m_rdata;
  bit         m_rhit;
  logic [7:0] m_mem [256];
  bit         m_vld [256];
  bit         model_ok = 1'b0;

  task automatic model_step();
    int         w;
    int         idx;
    bit         we_w;
    logic [7:0] a_w, d_w;
    logic [3:0] eg, ev;
    w = -1;
    if (!reset && !m_pend)
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (w < 0 && req[idx]) w = idx;
      end
    we_w = (w >= 0) ? req_we[w] : 1'b0;
    a_w  = (w >= 0) ? req_addr[8*w +: 8] : 8'h00;
    d_w  = (w >= 0) ? req_data[8*w +: 8] : 8'h00;
    eg   = (w >= 0) ? 4'(1 << w) : 4'b0000;
    ev   = (m_rowner >= 0) ? 4'(1 << m_rowner) : 4'b0000;
    if (model_ok) begin
      chk("m_gnt", 32'(gnt), 32'(eg));
      chk("m_rd_en", 32'(bank_read_enable), 32'(w >= 0 && !we_w));
      chk("m_wr_en", 32'(bank_write_enable), 32'(w >= 0 && we_w));
      if (w >= 0) chk("m_addr", 32'(bank_addr), 32'(a_w));
      if (w >= 0 && we_w) chk("m_wdata", 32'(bank_data_in), 32'(d_w));
      chk("m_resp_valid", 32'(resp_valid), 32'(ev));
      chk("m_resp_data", 32'(resp_data), 32'(m_rdata));
      chk("m_resp_hit", 32'(resp_hit), 32'(m_rhit));
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'(1));
      chk("en_exclusive", 32'(bank_read_enable & bank_write_enable), 32'(0));
      chk("gnt_implies_req", 32'(gnt & ~req), 32'(0));
    end
    if (reset) begin
      m_ptr = 0; m_pend = 1'b0; m_rowner = -1; m_rdata = 8'h00; m_rhit = 1'b0;
      for (int a = 0; a < 256; a++) begin
        m_mem[a] = 8'(a) ^ 8'h3C;
        m_vld[a] = 1'b0;
      end
      model_ok = 1'b1;
    end else begin
      m_rowner = -1;
      if (m_pend) begin
        m_rowner = m_owner;
        m_rdata  = m_mem[m_paddr];
        m_rhit   = m_vld[m_paddr];
        m_pend   = 1'b0;
      end
      if (w >= 0) begin
        m_ptr = (w + 1) % 4;
        if (we_w) begin
          m_mem[a_w] = d_w;
          m_vld[a_w] = 1'b1;
        end else begin
          m_pend  = 1'b1;
          m_owner = w;
          m_paddr = a_w;
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic set_op(input int i, input bit we, input logic [7:0] a, input logic [7:0] d);
    req_we[i]         = we;
    req_addr[8*i +: 8] = a;
    req_data[8*i +: 8] = d;
  endtask

  logic [3:0] wr_seq [5];

  initial begin
    reset = 1'b1; req = 4'b0; req_we = 4'b0; req_addr = 32'h0; req_data = 32'h0;
    wr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    mid(); chk("rst_gnt", 32'(gnt), 32'(0)); tick();
    reset = 1'b0;
    mid();
    chk("rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("rst_resp_data", 32'(resp_data), 32'(0));
    chk("rst_resp_hit", 32'(resp_hit), 32'(0));
    tick();

    // Requester 0 reads an unwritten address.
    req = 4'b0001; set_op(0, 1'b0, 8'h10, 8'h00);
    mid();
    chk("rd0_gnt", 32'(gnt), 32'(4'b0001));
    chk("rd0_rd_en", 32'(bank_read_enable), 32'(1));
    chk("rd0_addr", 32'(bank_addr), 32'(8'h10));
    tick();
    req = 4'b0000;
    mid(); chk("rd0_wait_gnt", 32'(gnt), 32'(0)); chk("rd0_wait_rv", 32'(resp_valid), 32'(0)); tick();
    mid(); chk("rd0_rv", 32'(resp_valid), 32'(4'b0001)); chk("rd0_hit", 32'(resp_hit), 32'(0)); tick();
    mid(); chk("rd0_rv_pulse", 32'(resp_valid), 32'(0)); tick();

    // Requester 2 writes, then requester 1 reads the same address.
    req = 4'b0100; set_op(2, 1'b1, 8'h10, 8'h5A);
    mid();
    chk("wr2_gnt", 32'(gnt), 32'(4'b0100));
    chk("wr2_wr_en", 32'(bank_write_enable), 32'(1));
    chk("wr2_wdata", 32'(bank_data_in), 32'(8'h5A));
    tick();
    req = 4'b0010; set_op(1, 1'b0, 8'h10, 8'h00);
    mid(); chk("rd1_gnt", 32'(gnt), 32'(4'b0010)); tick();
    req = 4'b0000;
    mid(); tick();
    mid();
    chk("rd1_rv", 32'(resp_valid), 32'(4'b0010));
    chk("rd1_data", 32'(resp_data), 32'(8'h5A));
    chk("rd1_hit", 32'(resp_hit), 32'(1));
    tick();

    // Continuous writes from all four starting at reset.
    reset = 1'b1; req = 4'b1111;
    for (int i = 0; i < 4; i++) set_op(i, 1'b1, 8'(8'h20 + i), 8'(8'hA0 + i));
    mid(); chk("wrall_rst_gnt", 32'(gnt), 32'(0)); chk("wrall_rst_wr_en", 32'(bank_write_enable), 32'(0)); tick();
    reset = 1'b0;
    for (int j = 0; j < 5; j++) begin
      mid(); chk("wrall_gnt", 32'(gnt), 32'(wr_seq[j])); tick();
    end

    // Continuous reads from all four; pointer starts at 1.
    for (int i = 0; i < 4; i++) set_op(i, 1'b0, 8'(8'h20 + i), 8'h00);
    for (int j = 0; j < 12; j++) begin
      mid();
      chk("rdall_gnt", 32'(gnt), (j % 2 == 0) ? 32'(1 << ((1 + j/2) % 4)) : 32'(0));
      if (j >= 2 && j % 2 == 0)
        chk("rdall_rv", 32'(resp_valid), 32'(1 << ((1 + (j-2)/2) % 4)));
      chk("rdall_overlap", 32'(gnt & resp_valid), 32'(0));
      if (resp_valid != 4'b0000) begin
        chk("rdall_data", 32'(resp_data), 32'(8'hA0) + 32'($clog2(resp_valid)));
        chk("rdall_hit", 32'(resp_hit), 32'(1));
      end
      tick();
    end
    req = 4'b0000;
    mid(); chk("rdall_last_rv", 32'(resp_valid), 32'(4'b0100)); tick();

    // A lone writer is granted every cycle.
    req = 4'b0001; set_op(0, 1'b1, 8'h30, 8'h77);
    for (int j = 0; j < 3; j++) begin
      mid(); chk("solo_gnt", 32'(gnt), 32'(4'b0001)); tick();
    end

    // Requester 0 gives up while requester 1's read is in flight.
    req = 4'b0011; set_op(0, 1'b0, 8'h30, 8'h00); set_op(1, 1'b0, 8'h21, 8'h00);
    mid(); chk("drop_gnt", 32'(gnt), 32'(4'b0010)); tick();
    req = 4'b0000;
    mid(); tick();
    mid();
    chk("drop_idle_gnt", 32'(gnt), 32'(0));
    chk("drop_rv", 32'(resp_valid), 32'(4'b0010));
    chk("drop_data", 32'(resp_data), 32'(8'hA1));
    tick();

    // Reset during the read wait drops the response and rewinds the pointer.
    req = 4'b0100; set_op(2, 1'b0, 8'h22, 8'h00);
    mid(); chk("rstwait_gnt", 32'(gnt), 32'(4'b0100)); tick();
    req = 4'b0000; reset = 1'b1;
    mid(); tick();
    reset = 1'b0; req = 4'b1010; set_op(1, 1'b1, 8'h40, 8'h11); set_op(3, 1'b1, 8'h41, 8'h33);
    mid(); chk("rstwait_no_rv", 32'(resp_valid), 32'(0)); chk("rstwait_gnt_low", 32'(gnt), 32'(4'b0010)); tick();
    mid(); chk("rstwait_no_rv2", 32'(resp_valid), 32'(0)); chk("rstwait_gnt_next", 32'(gnt), 32'(4'b1000)); tick();
    req = 4'b0000;
    mid(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bank_arbiter.md
BANK_ARBITER -- requirements
Module: bank_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock shared with the bank.
REQ-003 reset  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-004 req  input  4  per-requester access request; held high until the matching gnt bit is seen.
REQ-005 req_we  input  4  per-requester op: 1 = write, 0 = read; stable while req is high.
REQ-006 req_addr  input  32  four packed 8-bit addresses, requester i at bits [8i+7:8i].
REQ-007 req_data  input  32  four packed 8-bit write data, requester i at bits [8i+7:8i].
REQ-008 gnt  output  4  one-hot grant; requester i's command is accepted on the edge ending a gnt[i] cycle.
REQ-009 resp_valid  output  4  one-hot single-cycle read-response strobe.
REQ-010 resp_data  output  8  registered read data for the requester flagged by resp_valid.
REQ-011 resp_hit  output  1  registered bank valid bit; 1 = the address was written since reset.
REQ-012 bank_addr  output  8  address to the bank.
REQ-013 bank_data_in  output  8  write data to the bank.
REQ-014 bank_read_enable  output  1  bank read command.
REQ-015 bank_write_enable  output  1  bank write command.
REQ-016 bank_data_out  input  8  bank registered read data, valid the cycle after a read command.
REQ-017 bank_valid_out  input  1  bank registered valid bit, aligned with bank_data_out.

Function
REQ-018 The block SHALL implement a two-state FSM: IDLE, RD_WAIT.
REQ-019 In IDLE with any req bit high, the winner SHALL be the first set req bit scanning upward from rr_ptr (2 bits), wrapping 3->0.
REQ-020 gnt, bank_addr, bank_data_in and the bank enables SHALL be combinational from the winner in IDLE; with no winner they SHALL be 0.
REQ-021 At most one of bank_read_enable and bank_write_enable SHALL be high in any cycle.
REQ-022 On every grant edge, rr_ptr SHALL load winner+1 modulo 4.
REQ-023 A write grant SHALL complete in one cycle: state stays IDLE, and a new grant is possible in the next cycle.
REQ-024 A read grant SHALL move the state to RD_WAIT and latch the winner index in rd_owner.
REQ-025 In RD_WAIT, gnt and the bank enables SHALL be 0; all requests wait.
REQ-026 The edge leaving RD_WAIT SHALL register bank_data_out into resp_data, bank_valid_out into resp_hit, and set resp_valid[rd_owner] for exactly one cycle, then return to IDLE.
REQ-027 Read latency SHALL be 2 cycles: grant in cycle N, resp_valid in cycle N+2; a new grant is possible in cycle N+2.
REQ-028 resp_data and resp_hit SHALL hold their value between responses.
REQ-029 A req bit dropped before its grant SHALL be ignored without error.
REQ-030 When a single requester is active, it SHALL be granted every grant-eligible cycle.

Reset
REQ-031 With reset high, the following SHALL be forced at the next edge: state=IDLE, rr_ptr=0, resp_valid=0, resp_data=0, resp_hit=0.
REQ-032 gnt and the bank enables SHALL be 0 in any cycle where reset is high.
REQ-033 Reset asserted during RD_WAIT SHALL drop the pending response; no resp_valid pulse follows.

Verification
REQ-034 Reset, then read addr 0x10 from requester 0 -> gnt=0001 in cycle 1; resp_valid=0001, resp_hit=0, resp_data undefined-but-registered in cycle 3.
REQ-035 Requester 2 writes 0x5A to 0x10, then requester 1 reads 0x10 -> write gnt=0100 in one cycle; read response resp_valid=0010, resp_data=0x5A, resp_hit=1.
REQ-036 All four requesters issue continuous writes from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001, one per cycle.
REQ-037 All four requesters issue continuous reads -> gnt every other cycle in round-robin order; each resp_valid bit appears 2 cycles after its gnt; gnt and resp_valid never coincide on one index.
REQ-038 Reset is pulsed in the RD_WAIT cycle of a read -> no resp_valid; rr_ptr=0; the next grant goes to the lowest set req bit.
REQ-039 A checker SHALL assert on every cycle: gnt at most one-hot; never both bank enables; gnt[i] implies req[i].
